// File: rtl/game_loader_pkg.sv
// ============================================================================
//  Module      : game_loader_pkg
//  Description : Shared game codes, colours, screen size and loader state
//                encoding for the game loader and the game-select FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_loader_pkg;

    // Game codes shared with the game-select FSM
    localparam logic [2:0] GAME_PONG = 3'd0;
    localparam logic [2:0] GAME_DINO = 3'd1;

    // Colours {R,G,B}
    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    // Framebuffer geometry
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

`default_nettype wire

// File: rtl/game_loader_palette.sv
// ============================================================================
//  Module      : game_loader_palette
//  Description : Combinational pixel colour for a game's static screen:
//                background plus decoration (Pong net, Dino ground line).
//                Optional border enabled by GAME_LOADER_BORDER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_loader_palette
    import game_loader_pkg::*;
#(
    parameter int WIDTH    = SCREEN_W,
    parameter int HEIGHT   = SCREEN_H,
    parameter int GROUND_Y = 100,
    parameter int NET_X    = 80
) (
    input  logic [2:0] game,
    input  logic [7:0] cx,
    input  logic [6:0] cy,
    output logic [2:0] colour
);

    localparam logic [7:0] c_net_x    = 8'(NET_X);
    localparam logic [6:0] c_ground_y = 7'(GROUND_Y);
`ifdef GAME_LOADER_BORDER_EN
    localparam logic [7:0] c_x_last   = 8'(WIDTH - 1);
    localparam logic [6:0] c_y_last   = 7'(HEIGHT - 1);
`endif

    logic [2:0] w_bg;
    logic [2:0] w_deco_col;
    logic       w_deco_hit;
`ifdef GAME_LOADER_BORDER_EN
    logic [2:0] w_fg;
`endif

    // Pick background/decoration per game, then layer border and decoration
    always_comb begin
        w_bg       = COL_BLACK;
        w_deco_col = COL_BLACK;
        w_deco_hit = 1'b0;
`ifdef GAME_LOADER_BORDER_EN
        w_fg       = COL_BLACK;
`endif
        case (game)
            GAME_PONG: begin
                w_bg       = COL_BLACK;
                w_deco_col = COL_WHITE;
                // Dashed net: 4 rows on, 4 rows off
                w_deco_hit = (cx == c_net_x) && !cy[2];
`ifdef GAME_LOADER_BORDER_EN
                w_fg       = COL_WHITE;
`endif
            end
            GAME_DINO: begin
                w_bg       = COL_WHITE;
                w_deco_col = COL_BLACK;
                w_deco_hit = (cy == c_ground_y);
`ifdef GAME_LOADER_BORDER_EN
                w_fg       = COL_BLACK;
`endif
            end
            default: begin
                w_bg       = COL_BLACK;
                w_deco_col = COL_BLACK;
                w_deco_hit = 1'b0;
            end
        endcase

        colour = w_bg;
`ifdef GAME_LOADER_BORDER_EN
        if ((cx == 8'd0) || (cx == c_x_last) || (cy == 7'd0) || (cy == c_y_last)) begin
            colour = w_fg;
        end
`endif
        if (w_deco_hit) begin
            colour = w_deco_col;
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_loader.sv
// ============================================================================
//  Module      : game_loader
//  Description : Responder side of the game-select load handshake. On load,
//                latches the game code and raster-scans the framebuffer,
//                one registered pixel per unstalled cycle, then holds
//                doneLoading until load falls.
//                Optional macro: GAME_LOADER_BORDER_EN (screen border).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_loader
    import game_loader_pkg::*;
#(
    parameter int WIDTH    = SCREEN_W,
    parameter int HEIGHT   = SCREEN_H,
    parameter int GROUND_Y = 100,
    parameter int NET_X    = 80
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic [2:0] game,
    input  logic       stall,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       doneLoading
);

    localparam logic [7:0] c_x_last = 8'(WIDTH - 1);
    localparam logic [6:0] c_y_last = 7'(HEIGHT - 1);

    load_state_t r_state, w_state_n;
    logic [2:0]  r_g, w_g_n;
    logic [7:0]  r_cx, w_cx_n;
    logic [6:0]  r_cy, w_cy_n;
    logic [7:0]  r_x, w_x_n;
    logic [6:0]  r_y, w_y_n;
    logic [2:0]  r_colour, w_colour_n;
    logic        r_plot, w_plot_n;
    logic        r_done, w_done_n;
    logic [2:0]  w_pix_col;

    game_loader_palette #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .GROUND_Y (GROUND_Y),
        .NET_X    (NET_X)
    ) u_palette (
        .game   (r_g),
        .cx     (r_cx),
        .cy     (r_cy),
        .colour (w_pix_col)
    );

    // Next-state, scan counters and registered pixel outputs
    always_comb begin
        w_state_n  = r_state;
        w_g_n      = r_g;
        w_cx_n     = r_cx;
        w_cy_n     = r_cy;
        w_x_n      = r_x;
        w_y_n      = r_y;
        w_colour_n = r_colour;
        w_plot_n   = 1'b0;
        w_done_n   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_state_n = ST_SCAN;
                    w_g_n     = game;
                    w_cx_n    = 8'd0;
                    w_cy_n    = 7'd0;
                end
            end
            ST_SCAN: begin
                // Abort takes priority, even on the final pixel
                if (!load) begin
                    w_state_n = ST_IDLE;
                end else if (!stall) begin
                    w_x_n      = r_cx;
                    w_y_n      = r_cy;
                    w_colour_n = w_pix_col;
                    w_plot_n   = 1'b1;
                    if ((r_cx == c_x_last) && (r_cy == c_y_last)) begin
                        w_state_n = ST_DONE;
                    end else if (r_cx == c_x_last) begin
                        w_cx_n = 8'd0;
                        w_cy_n = r_cy + 7'd1;
                    end else begin
                        w_cx_n = r_cx + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                // Held level for the slow requester; drops with load
                if (!load) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_done_n = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_g      <= 3'd0;
            r_cx     <= 8'd0;
            r_cy     <= 7'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_g      <= w_g_n;
            r_cx     <= w_cx_n;
            r_cy     <= w_cy_n;
            r_x      <= w_x_n;
            r_y      <= w_y_n;
            r_colour <= w_colour_n;
            r_plot   <= w_plot_n;
            r_done   <= w_done_n;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign colour      = r_colour;
    assign plot        = r_plot;
    assign doneLoading = r_done;

endmodule

`default_nettype wire

// File: tb/tb_game_loader.sv
// ============================================================================
//  Module      : tb_game_loader
//  Description : Self-checking bench for game_loader with randomized stall
//                and a behavioural screen model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_game_loader;

    logic       clock = 1'b0;
    logic       resetn;
    logic       load;
    logic [2:0] game;
    logic       stall;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       doneLoading;

    int checks = 0;
    int errors = 0;
    int plots, first_pc, last_pc, cyc;
    logic [2:0] fb [0:19199];

    always #10 clock = ~clock;

    game_loader dut (
        .clock       (clock),
        .resetn      (resetn),
        .load        (load),
        .game        (game),
        .stall       (stall),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .doneLoading (doneLoading)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Screen contents straight from the game rules
    function automatic logic [2:0] model_colour(input int g, input int px, input int py);
        logic [2:0] c;
`ifdef GAME_LOADER_BORDER_EN
        logic [2:0] fg;
        fg = (g == 0) ? 3'b111 : 3'b000;
`endif
        if (g == 0)      c = (px == 80 && (py % 8) < 4) ? 3'b111 : 3'b000;
        else if (g == 1) c = (py == 100) ? 3'b000 : 3'b111;
        else             c = 3'b000;
`ifdef GAME_LOADER_BORDER_EN
        // Decoration colours coincide with the foreground, so border wins cleanly
        if (px == 0 || px == 159 || py == 0 || py == 119) c = fg;
`endif
        return c;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Request a load and follow the scan pixel by pixel against the model
    task automatic run_scan(input int g, input int stall_pct, input int switch_at, input int stop_at);
        plots    = 0;
        first_pc = -1;
        last_pc  = -1;
        cyc      = 0;
        load     = 1'b1;
        game     = 3'(g);
        while (1) begin
            logic st;
            st    = ($urandom_range(99) < stall_pct);
            stall = st;
            if (plots == switch_at) game = 3'(g + 1);
            step();
            cyc++;
            if (st) check("stall_hold", {31'd0, plot}, 32'd0);
            if (plot) begin
                int ex;
                int ey;
                ex = plots % 160;
                ey = plots / 160;
                check("pixel", {13'd0, doneLoading, x, y, colour},
                      {13'd0, 1'b0, 8'(ex), 7'(ey), model_colour(g, ex, ey)});
                if (plots < 19200) fb[plots] = colour;
                if (first_pc < 0) first_pc = cyc;
                last_pc = cyc;
                plots++;
            end
            if (doneLoading || plots == stop_at) break;
            if (cyc >= 40000) begin
                check("timeout", 32'(cyc), 32'd0);
                break;
            end
        end
        stall = 1'b0;
    endtask

    task automatic hold_done(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            step();
            if (!doneLoading || plot) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic quiet(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            step();
            if (doneLoading || plot) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        load   = 1'b0;
        stall  = 1'b0;
        game   = 3'd0;
        repeat (3) step();
        check("reset", {13'd0, plot, doneLoading, x, y, colour}, 32'd0);
        resetn = 1'b1;
        quiet("idle", 4);

        // Pong with random stalls; game switched to Dino mid-scan is ignored
        run_scan(0, 30, 5000, -1);
        check("s1_plots", 32'(plots), 32'd19200);
        check("s1_done_lat", 32'(cyc), 32'(last_pc + 1));
        check("pong_80_0", {29'd0, fb[80]}, 32'd7);
        check("pong_80_4", {29'd0, fb[4*160+80]}, 32'd0);
        check("pong_10_10", {29'd0, fb[10*160+10]}, 32'd0);
        hold_done("s1_done_hold", 5);
        load = 1'b0;
        step();
        check("s1_done_drop", {31'd0, doneLoading}, 32'd0);
        step();

        // Dino unstalled: exact latency
        run_scan(1, 0, -1, -1);
        check("s2_plots", 32'(plots), 32'd19200);
        check("s2_total", 32'(cyc), 32'd19202);
        check("s2_first", 32'(first_pc), 32'd2);
        check("dino_5_100", {29'd0, fb[100*160+5]}, 32'd0);
        check("dino_5_99", {29'd0, fb[99*160+5]}, 32'd7);
`ifdef GAME_LOADER_BORDER_EN
        check("dino_0_50", {29'd0, fb[50*160]}, 32'd0);
        check("dino_1_50", {29'd0, fb[50*160+1]}, 32'd7);
`endif
        hold_done("s2_done_hold", 3);
        load = 1'b0;
        step();
        check("s2_done_drop", {31'd0, doneLoading}, 32'd0);

        // Abort after 1000 pixels
        run_scan(0, 0, -1, 1000);
        check("ab_plots", 32'(plots), 32'd1000);
        load = 1'b0;
        step();
        check("ab_stop", {30'd0, plot, doneLoading}, 32'd0);
        quiet("ab_quiet", 20);

        // Restart from (0,0) with a blank game, then reset at pixel 500
        run_scan(5, 0, -1, 500);
        check("rs_plots", 32'(plots), 32'd500);
        resetn = 1'b0;
        step();
        check("rst_mid", {15'd0, plot, doneLoading, x, y}, 32'd0);
        resetn = 1'b1;
        run_scan(5, 20, -1, 2000);
        check("rs2_plots", 32'(plots), 32'd2000);
        load = 1'b0;
        step();
        quiet("end_quiet", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog got=expired exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
